// File: rtl/uart_tx_framed_pkg.sv
// uart_pkg: shared types for the UART transmitter (and the future receiver).
//   parity_t         - parity mode selector used as a module parameter
//   uart_tx_state_e  - transmitter state set
//   frame_bits()     - total bits on the line for one frame
package uart_pkg;

    typedef enum logic [1:0] {
        PARITY_NONE = 2'd0,
        PARITY_EVEN = 2'd1,
        PARITY_ODD  = 2'd2
    } parity_t;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4,
        BREAK  = 3'd5,
        MARK   = 3'd6
    } uart_tx_state_e;

    // Start bit + payload + optional parity + stop bits.
    function automatic int frame_bits(input int data_bits, input parity_t parity,
                                      input int stop_bits);
        return 1 + data_bits + ((parity != PARITY_NONE) ? 1 : 0) + stop_bits;
    endfunction

endpackage

// File: rtl/uart_tx_framed_if.sv
// axis_interface: minimal AXI-Stream link (tdata/tvalid/tready).
//   clk     - stream clock; must be the same net as the consumer's clk
//   tdata   - DATA_W bits of payload, source -> sink
//   tvalid  - source has data
//   tready  - sink accepts data this cycle
// Modports: Source/Sink (master/slave are aliases of the same directions).
interface axis_interface #(
    parameter int DATA_W = 8
) (
    input logic clk
);
    logic [DATA_W-1:0] tdata;
    logic              tvalid;
    logic              tready;

    modport Source (input clk, input tready, output tdata, output tvalid);
    modport Sink   (input tdata, input tvalid, output tready);
    modport master (input clk, input tready, output tdata, output tvalid);
    modport slave  (input tdata, input tvalid, output tready);
endinterface

// File: rtl/uart_tx_framed_baud_tick.sv
// uart_baud_tick: bit-period timer shared by the UART TX and RX.
//   clk       - system clock
//   rst_n     - synchronous active-low reset
//   clear     - restart the bit period (counter back to 0)
//   bit_tick  - high for one cycle at the end of every CLKS_PER_BIT-cycle period
module uart_baud_tick #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    output logic bit_tick
);
    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // Tick on the last cycle of the period so the caller advances exactly
    // CLKS_PER_BIT cycles after the clear.
    assign bit_tick = (cnt == LAST);
endmodule

// File: rtl/uart_tx_framed.sv
// uart_tx_framed: parametrised UART transmitter fed from an AXI-Stream sink.
//   clk        - system clock (stream.clk must be the same net)
//   rst_n      - synchronous active-low reset
//   stream     - axis_interface.Sink; tdata[DATA_BITS-1:0] is the payload
//   break_req  - (only with UART_TX_BREAK_EN) request a line break
//   txd        - registered serial output, idle/mark = 1
//   busy       - high whenever the transmitter is not idle
// Optional feature macro: UART_TX_BREAK_EN adds break_req and the BREAK/MARK states.
module uart_tx_framed
    import uart_pkg::*;
#(
    parameter int      CLKS_PER_BIT = 868,
    parameter int      DATA_BITS    = 8,
    parameter parity_t PARITY       = PARITY_NONE,
    parameter int      STOP_BITS    = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    axis_interface.Sink  stream,
`ifdef UART_TX_BREAK_EN
    input  logic         break_req,
`endif
    output logic         txd,
    output logic         busy
);
    if (CLKS_PER_BIT < 2) begin : g_bad_cpb
        $error("uart_tx_framed: CLKS_PER_BIT must be >= 2");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data
        $error("uart_tx_framed: DATA_BITS must be 5..9");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
        $error("uart_tx_framed: STOP_BITS must be 1..2");
    end

    localparam logic [2:0] ST_IDLE   = uart_pkg::IDLE;
    localparam logic [2:0] ST_START  = uart_pkg::START;
    localparam logic [2:0] ST_DATA   = uart_pkg::DATA;
    localparam logic [2:0] ST_PARITY = uart_pkg::PARITY;
    localparam logic [2:0] ST_STOP   = uart_pkg::STOP;
`ifdef UART_TX_BREAK_EN
    localparam logic [2:0] ST_BREAK  = uart_pkg::BREAK;
    localparam logic [2:0] ST_MARK   = uart_pkg::MARK;
    localparam int         FRAME_BITS = frame_bits(DATA_BITS, PARITY, STOP_BITS);
    localparam int         BREAK_MIN  = FRAME_BITS * CLKS_PER_BIT;
    localparam int         BW         = $clog2(BREAK_MIN);
    localparam logic [BW-1:0] BREAK_LAST = BW'(BREAK_MIN - 1);
`endif

    localparam logic [3:0] DATA_LAST = 4'(DATA_BITS - 1);
    localparam logic [3:0] STOP_LAST = 4'(STOP_BITS - 1);

    function automatic logic parity_of(input logic [DATA_BITS-1:0] d);
        case (PARITY)
            PARITY_EVEN: return ^d;
            PARITY_ODD:  return ~^d;
            default:     return 1'b0;
        endcase
    endfunction

    logic [2:0]           state;
    logic [3:0]           idx;
    logic [DATA_BITS-1:0] shreg;
    logic                 par_bit;
    logic                 ready;
    logic                 hs;
    logic                 bit_tick;
    logic                 tick_clear;

`ifdef UART_TX_BREAK_EN
    logic [BW-1:0] brk_cnt;
    logic          to_mark;

    // brk_cnt saturates at BREAK_LAST, so equality means the minimum is met.
    assign to_mark    = (state == ST_BREAK) && !break_req && (brk_cnt == BREAK_LAST);
    assign ready      = (state == ST_IDLE) && rst_n && !break_req;
    assign tick_clear = hs || to_mark;
`else
    assign ready      = (state == ST_IDLE) && rst_n;
    assign tick_clear = hs;
`endif

    assign stream.tready = ready;
    assign hs            = ready && stream.tvalid;
    assign busy          = (state != ST_IDLE);

    uart_baud_tick #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tick (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (tick_clear),
        .bit_tick (bit_tick)
    );

    // Payload path: captured at the handshake, shifted out LSB first.
    always_ff @(posedge clk) begin
        if (hs) begin
            shreg   <= stream.tdata[DATA_BITS-1:0];
            par_bit <= parity_of(stream.tdata[DATA_BITS-1:0]);
        end else if (bit_tick && (state == ST_START || state == ST_DATA)) begin
            shreg <= shreg >> 1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            txd     <= 1'b1;
            idx     <= '0;
`ifdef UART_TX_BREAK_EN
            brk_cnt <= '0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
`ifdef UART_TX_BREAK_EN
                    if (break_req) begin
                        state   <= ST_BREAK;
                        txd     <= 1'b0;
                        brk_cnt <= '0;
                    end else
`endif
                    if (hs) begin
                        state <= ST_START;
                        txd   <= 1'b0;
                        idx   <= '0;
                    end
                end
                ST_START: begin
                    if (bit_tick) begin
                        state <= ST_DATA;
                        txd   <= shreg[0];
                        idx   <= '0;
                    end
                end
                ST_DATA: begin
                    if (bit_tick) begin
                        if (idx == DATA_LAST) begin
                            idx <= '0;
                            if (PARITY != PARITY_NONE) begin
                                state <= ST_PARITY;
                                txd   <= par_bit;
                            end else begin
                                state <= ST_STOP;
                                txd   <= 1'b1;
                            end
                        end else begin
                            idx <= idx + 1'b1;
                            txd <= shreg[0];
                        end
                    end
                end
                ST_PARITY: begin
                    if (bit_tick) begin
                        state <= ST_STOP;
                        txd   <= 1'b1;
                        idx   <= '0;
                    end
                end
                ST_STOP: begin
                    if (bit_tick) begin
                        if (idx == STOP_LAST) begin
                            state <= ST_IDLE;
                            txd   <= 1'b1;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                end
`ifdef UART_TX_BREAK_EN
                ST_BREAK: begin
                    if (to_mark) begin
                        state <= ST_MARK;
                        txd   <= 1'b1;
                    end else if (brk_cnt != BREAK_LAST) begin
                        brk_cnt <= brk_cnt + 1'b1;
                    end
                end
                ST_MARK: begin
                    if (bit_tick) begin
                        state <= ST_IDLE;
                    end
                end
`endif
                default: begin
                    state <= ST_IDLE;
                    txd   <= 1'b1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx_framed.sv
// Testbench for uart_tx_framed: four configurations (8N1, 8E1, 8O1, 7N2) at
// CLKS_PER_BIT=4 side by side, a frame-level reference model checked every
// cycle, and hand-computed literal expectations at key points.
// Break tests are included when UART_TX_BREAK_EN is defined.
module tb_uart_tx_framed;
    import uart_pkg::*;

    localparam int CPB = 4;
    localparam int NI  = 4;

    function automatic int db(input int i);  return (i == 3) ? 7 : 8; endfunction
    function automatic int pm(input int i);  return (i == 1) ? 1 : ((i == 2) ? 2 : 0); endfunction
    function automatic int sb(input int i);  return (i == 3) ? 2 : 1; endfunction
    function automatic int fbits(input int i);
        return 1 + db(i) + ((pm(i) != 0) ? 1 : 0) + sb(i);
    endfunction

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       brk = 1'b0;
    logic       chk_en = 1'b0;
    logic       tv[NI];
    logic [7:0] td[NI];
    logic       txd_w[NI];
    logic       busy_w[NI];
    logic       rdy_w[NI];

    int vec  = 0;
    int miss = 0;

    always #5 clk = ~clk;

    axis_interface #(.DATA_W(8)) s0 (.clk(clk));
    axis_interface #(.DATA_W(8)) s1 (.clk(clk));
    axis_interface #(.DATA_W(8)) s2 (.clk(clk));
    axis_interface #(.DATA_W(8)) s3 (.clk(clk));

    assign s0.tvalid = tv[0]; assign s0.tdata = td[0]; assign rdy_w[0] = s0.tready;
    assign s1.tvalid = tv[1]; assign s1.tdata = td[1]; assign rdy_w[1] = s1.tready;
    assign s2.tvalid = tv[2]; assign s2.tdata = td[2]; assign rdy_w[2] = s2.tready;
    assign s3.tvalid = tv[3]; assign s3.tdata = td[3]; assign rdy_w[3] = s3.tready;

    uart_tx_framed #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(PARITY_NONE), .STOP_BITS(1)) u0 (
        .clk(clk), .rst_n(rst_n), .stream(s0),
`ifdef UART_TX_BREAK_EN
        .break_req(brk),
`endif
        .txd(txd_w[0]), .busy(busy_w[0]));
    uart_tx_framed #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(PARITY_EVEN), .STOP_BITS(1)) u1 (
        .clk(clk), .rst_n(rst_n), .stream(s1),
`ifdef UART_TX_BREAK_EN
        .break_req(brk),
`endif
        .txd(txd_w[1]), .busy(busy_w[1]));
    uart_tx_framed #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(PARITY_ODD), .STOP_BITS(1)) u2 (
        .clk(clk), .rst_n(rst_n), .stream(s2),
`ifdef UART_TX_BREAK_EN
        .break_req(brk),
`endif
        .txd(txd_w[2]), .busy(busy_w[2]));
    uart_tx_framed #(.CLKS_PER_BIT(CPB), .DATA_BITS(7), .PARITY(PARITY_NONE), .STOP_BITS(2)) u3 (
        .clk(clk), .rst_n(rst_n), .stream(s3),
`ifdef UART_TX_BREAK_EN
        .break_req(brk),
`endif
        .txd(txd_w[3]), .busy(busy_w[3]));

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vec++;
        if (act !== exp) begin
            miss++;
            $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: per instance, mode 0=idle 1=frame 2=break 3=mark.
    // A frame is the list of line bits; the line shows bit pos/CPB.
    int m_mode[NI];
    int m_pos[NI];
    int m_bk[NI];
    bit m_bits[NI][16];

    always @(posedge clk) begin
        for (int i = 0; i < NI; i++) begin
            if (!rst_n) begin
                m_mode[i] = 0;
            end else begin
                case (m_mode[i])
                    0: begin
                        if (brk) begin
                            m_mode[i] = 2;
                            m_bk[i]   = 0;
                        end else if (tv[i]) begin
                            bit p;
                            int k;
                            p = 1'b0;
                            k = 0;
                            m_bits[i][k] = 1'b0; k++;
                            for (int d = 0; d < db(i); d++) begin
                                m_bits[i][k] = td[i][d]; k++;
                                p = p ^ td[i][d];
                            end
                            if (pm(i) == 1) begin m_bits[i][k] = p;  k++; end
                            if (pm(i) == 2) begin m_bits[i][k] = !p; k++; end
                            for (int s = 0; s < sb(i); s++) begin
                                m_bits[i][k] = 1'b1; k++;
                            end
                            m_mode[i] = 1;
                            m_pos[i]  = 0;
                        end
                    end
                    1: begin
                        m_pos[i]++;
                        if (m_pos[i] == fbits(i) * CPB) m_mode[i] = 0;
                    end
                    2: begin
                        m_bk[i]++;
                        if (!brk && m_bk[i] >= fbits(i) * CPB) begin
                            m_mode[i] = 3;
                            m_pos[i]  = 0;
                        end
                    end
                    default: begin
                        m_pos[i]++;
                        if (m_pos[i] == CPB) m_mode[i] = 0;
                    end
                endcase
            end
        end
    end

    function automatic logic exp_txd(input int i);
        case (m_mode[i])
            1:       return m_bits[i][m_pos[i] / CPB];
            2:       return 1'b0;
            default: return 1'b1;
        endcase
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < NI; i++) begin
                chk($sformatf("model_txd%0d", i),  txd_w[i],  exp_txd(i));
                chk($sformatf("model_busy%0d", i), busy_w[i], m_mode[i] != 0);
                chk($sformatf("model_rdy%0d", i),  rdy_w[i],  (m_mode[i] == 0) && rst_n && !brk);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, miscompares %0d", miss);
        $fatal(1, "watchdog");
    end

    logic [10:0] lit_a[NI];
    logic [9:0]  lit_b;
    int          idle_at;
    int          start_at;
    int          zeros;

    initial begin
        // Line bits per slot, slot 0 = LSB.
        lit_a[0] = 11'b11010101010;   // 8N1 0x55, then idle
        lit_a[1] = 11'b11000001110;   // 8E1 0x07, parity 1
        lit_a[2] = 11'b10000001110;   // 8O1 0x07, parity 0
        lit_a[3] = 11'b11111111110;   // 7N2 0xFF, bit 7 ignored
        lit_b    = 10'b1100000000;    // 7N2 0x80: start, seven 0s, two stops
        for (int i = 0; i < NI; i++) begin
            tv[i] = 1'b0;
            td[i] = 8'h00;
        end

        // Reset
        @(posedge clk);
        #1 chk_en = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_txd", txd_w[0], 1'b1);
        chk("rst_busy", busy_w[0], 1'b0);
        chk("rst_tready", rdy_w[0], 1'b0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_tready", rdy_w[0], 1'b1);

        // Single frames on all four configurations
        @(posedge clk);
        #1;
        td[0] = 8'h55; td[1] = 8'h07; td[2] = 8'h07; td[3] = 8'hFF;
        for (int i = 0; i < NI; i++) tv[i] = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < NI; i++) tv[i] = 1'b0;
        for (int c = 0; c < 44; c++) begin
            @(negedge clk);
            if (c % 4 == 1) begin
                for (int i = 0; i < NI; i++)
                    chk($sformatf("frame%0d_slot%0d", i, c / 4), txd_w[i], lit_a[i][c / 4]);
            end
            if (c == 1) begin
                chk("frame_busy", busy_w[0], 1'b1);
                chk("frame_tready", rdy_w[0], 1'b0);
            end
            if (c == 40) begin
                chk("end_busy", busy_w[0], 1'b0);
                chk("end_tready", rdy_w[0], 1'b1);
            end
        end
        repeat (4) @(posedge clk);

        // 7N2 with only the ignored-width MSB set
        #1;
        td[3] = 8'h80; tv[3] = 1'b1;
        @(posedge clk);
        #1 tv[3] = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (c % 4 == 1) chk($sformatf("msb_slot%0d", c / 4), txd_w[3], lit_b[c / 4]);
        end
        repeat (4) @(posedge clk);

        // Back-to-back frames with tvalid held; tdata changes after handshake
        #1;
        td[0] = 8'hA5; tv[0] = 1'b1;
        @(posedge clk);
        #1 td[0] = 8'h3C;
        idle_at  = -1;
        start_at = -1;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (idle_at < 0 && !busy_w[0]) idle_at = c;
            else if (idle_at >= 0 && busy_w[0]) begin
                start_at = c;
                break;
            end
        end
        chk("b2b_idle_cycle", idle_at, 40);
        chk("b2b_second_start", start_at, 41);
        chk("b2b_start_bit", txd_w[0], 1'b0);
        tv[0] = 1'b0;
        repeat (50) @(posedge clk);

        // Reset during data bit 3
        #1;
        td[0] = 8'h00; tv[0] = 1'b1;
        @(posedge clk);
        #1 tv[0] = 1'b0;
        repeat (18) @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("abort_txd", txd_w[0], 1'b1);
        chk("abort_busy", busy_w[0], 1'b0);
        chk("abort_tready", rdy_w[0], 1'b0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("release_tready", rdy_w[0], 1'b1);
        chk("release_txd", txd_w[0], 1'b1);
        repeat (4) @(posedge clk);

`ifdef UART_TX_BREAK_EN
        // Long break with a byte waiting behind it
        #1;
        td[0] = 8'h5A; tv[0] = 1'b1; brk = 1'b1;
        zeros = 0;
        for (int c = 0; c < 106; c++) begin
            @(negedge clk);
            if (c < 100 && txd_w[0] == 1'b0) zeros++;
            if (c == 99) brk = 1'b0;
            if (c >= 100 && c <= 104) chk($sformatf("mark_c%0d", c), txd_w[0], 1'b1);
            if (c == 105) begin
                chk("after_break_start", txd_w[0], 1'b0);
                tv[0] = 1'b0;
            end
        end
        chk("long_break_low", zeros, 100);
        repeat (50) @(posedge clk);

        // Short request still holds the line low for a full frame time
        #1 brk = 1'b1;
        zeros = 0;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (txd_w[0] == 1'b0) zeros++;
            if (c == 9) brk = 1'b0;
        end
        chk("short_break_low", zeros, 40);
        repeat (10) @(posedge clk);
`endif

        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end
endmodule
